// File: rtl/sll_iter.sv
// -----------------------------------------------------------------------------
// sll_iter
// Multicycle 32-bit logical left shifter. An operand and a 5-bit shift amount
// are taken on a valid/ready handshake. One binary-weighted stage is applied
// per clock (16, 8, 4, 2, 1). The result is then held on a valid/ready output
// handshake until the consumer takes it. Latency from accept to out_valid is
// fixed at 5 clocks, whatever the shift amount.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous, active-low reset
//   in_valid   in   1   operand/shamt present
//   in_ready   out  1   block can accept (IDLE only)
//   data_in    in   32  operand
//   shamt      in   5   shift amount 0..31
//   out_valid  out  1   data_out holds a completed result
//   out_ready  in   1   consumer takes the result
//   data_out   out  32  shifted result (the work register)
//   busy       out  1   high in any state other than IDLE
// -----------------------------------------------------------------------------
module sll_iter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S16  = 3'd1,
        S8   = 3'd2,
        S4   = 3'd3,
        S2   = 3'd4,
        S1   = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] work_r;
    logic [31:0] work_nxt_s;
    logic [4:0]  amount_r;
    logic [4:0]  amount_nxt_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;

    // One conditional stage: shift by the stage weight when its amount bit is set.
    function automatic logic [31:0] stage_shift(input logic [31:0] value,
                                                input logic        enable,
                                                input logic [4:0]  weight);
        logic [31:0] result;
        if (enable) begin
            result = value << weight;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Next-state, work and amount update logic.
    always_comb begin
        state_nxt_s  = state_r;
        work_nxt_s   = work_r;
        amount_nxt_s = amount_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s  = S16;
                    work_nxt_s   = data_in;
                    amount_nxt_s = shamt;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            S16: begin
                work_nxt_s  = stage_shift(work_r, amount_r[4], 5'd16);
                state_nxt_s = S8;
            end
            S8: begin
                work_nxt_s  = stage_shift(work_r, amount_r[3], 5'd8);
                state_nxt_s = S4;
            end
            S4: begin
                work_nxt_s  = stage_shift(work_r, amount_r[2], 5'd4);
                state_nxt_s = S2;
            end
            S2: begin
                work_nxt_s  = stage_shift(work_r, amount_r[1], 5'd2);
                state_nxt_s = S1;
            end
            S1: begin
                work_nxt_s  = stage_shift(work_r, amount_r[0], 5'd1);
                state_nxt_s = DONE;
            end
            DONE: begin
                // No accept in the handshake cycle: always pass through IDLE.
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                work_nxt_s   = 32'd0;
                amount_nxt_s = 5'd0;
            end
        endcase
    end

    // State, datapath and output-flag registers.
    // The flags are decoded from the next state, so they match the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            work_r      <= 32'd0;
            amount_r    <= 5'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            work_r      <= work_nxt_s;
            amount_r    <= amount_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign data_out  = work_r;

endmodule

// File: tb/tb_sll_iter.sv
// -----------------------------------------------------------------------------
// tb_sll_iter
// Directed self-checking bench for sll_iter. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected values are hand-computed
// constants, or data << shamt for the pseudo-random sweep.
// -----------------------------------------------------------------------------
module tb_sll_iter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        busy;

    int n_checks;
    int n_pass;
    int n_fail;
    int cyc;

    sll_iter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Rising-edge counter used to measure the issue interval.
    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete operation: accept, wait for the result, stall, then handshake.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input int stall,
                         input string tag);
        int          guard;
        int          lat;
        logic [31:0] exp;
        logic [31:0] held;
        exp   = d << s;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        data_in   = d;
        shamt     = s;
        out_ready = (stall == 0);
        @(negedge clock);
        in_valid = 1'b0;
        data_in  = $urandom;
        shamt    = 5'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " data"}, data_out, exp);
        held = data_out;
        repeat (stall) @(negedge clock);
        if (stall > 0) begin
            check({tag, " stall hold"}, data_out, held);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] bd [2];
        logic [4:0]  bs [2];
        logic [31:0] bres [2];
        int          acc_cyc [2];
        int          idx;
        int          got;
        int          guard;
        logic [31:0] held;
        logic        seen;
        logic [31:0] rd;
        logic [4:0]  rs;

        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 32'd0;
        shamt     = 5'd0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("reset data_out", data_out, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle after release", {29'd0, in_ready, out_valid, busy}, 32'd4);

        // Basic and zero-shift/truncation cases.
        do_op(32'h0000_0001, 5'd31, 0, "basic 1<<31");
        do_op(32'hDEAD_BEEF, 5'd0,  0, "zero shift");
        do_op(32'hDEAD_BEEF, 5'd16, 0, "shift 16");
        do_op(32'hDEAD_BEEF, 5'd4,  0, "shift 4");

        // Backpressure: hold out_ready low with in_valid toggling.
        in_valid = 1'b1;
        data_in  = 32'h0000_00F0;
        shamt    = 5'd3;
        @(negedge clock);
        data_in  = 32'h1111_1111;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("bp result", data_out, 32'h0000_0780);
        held = data_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            data_in  = $urandom;
            shamt    = 5'($urandom);
            @(negedge clock);
            check("bp hold data", data_out, held);
            check("bp hold flags", {29'd0, in_ready, out_valid, busy}, 32'd3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("bp release", {29'd0, in_ready, out_valid, busy}, 32'd4);
        @(negedge clock);
        check("bp no stray accept", {31'd0, busy}, 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        bd[0] = 32'hFFFF_FFFF; bs[0] = 5'd1; bres[0] = 32'hFFFF_FFFE;
        bd[1] = 32'h1234_5678; bs[1] = 5'd8; bres[1] = 32'h3456_7800;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        idx = 0;
        got = 0;
        guard = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 2 && guard < 40) begin
            if (out_valid) begin
                check("b2b result", data_out, bres[got]);
                got++;
            end
            if (in_ready && idx < 2) begin
                data_in = bd[idx];
                shamt   = bs[idx];
                acc_cyc[idx] = cyc;
                idx++;
            end else if (idx >= 2) begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b count", 32'(got), 32'd2);
        check("b2b interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);

        // Reset asserted while in S4.
        @(negedge clock);
        in_valid = 1'b1;
        data_in  = 32'hA5A5_A5A5;
        shamt    = 5'd3;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("async reset data", data_out, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("no stale result", {31'd0, seen}, 32'd0);
        do_op(32'h0000_0003, 5'd2, 0, "after reset 3<<2");

        // Pseudo-random sweep with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            rs = 5'($urandom_range(31, 0));
            do_op(rd, rs, int'($urandom_range(3, 0)), "sweep");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
